// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified instruction/data memory port arbiter:
// requester tags, FSM state encoding and default geometry.
package mem_arb_pkg;

   localparam int AW_DEF = 10;
   localparam int DW_DEF = 32;

   // Requester tags double as bit positions in the request/grant vectors.
   localparam logic [1:0] TAG_IF = 2'd0;
   localparam logic [1:0] TAG_DM = 2'd1;
   localparam logic [1:0] TAG_LD = 2'd2;

   typedef enum logic {
      ST_NORMAL = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_e;

endpackage

// File: rtl/mem_arb_prio.sv
// Combinational one-hot priority picker: locked loader > forced loader > DM > IF > LD.
// Grants depend only on the current requests and mode inputs, never on other grants.
module mem_arb_prio
   import mem_arb_pkg::*;
(
   input  logic [2:0] i_reqs,
   input  logic       i_force_ld,
   input  logic       i_locked,
   output logic [2:0] o_gnt
);

   // Pick at most one winner from the request vector
   always_comb begin
      o_gnt = 3'b000;
      if (i_locked) begin
         o_gnt[TAG_LD] = i_reqs[TAG_LD];
      end else if (i_force_ld & i_reqs[TAG_LD]) begin
         o_gnt[TAG_LD] = 1'b1;
      end else if (i_reqs[TAG_DM]) begin
         o_gnt[TAG_DM] = 1'b1;
      end else if (i_reqs[TAG_IF]) begin
         o_gnt[TAG_IF] = 1'b1;
      end else if (i_reqs[TAG_LD]) begin
         o_gnt[TAG_LD] = 1'b1;
      end else begin
         o_gnt = 3'b000;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for IF, DM and loader requesters with a loader
// starvation guard, a burst lock mode, a registered command and tagged read return.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW           = AW_DEF,
   parameter int DW           = DW_DEF,
   parameter int STARVE_LIMIT = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic          dm_gnt,
   input  logic          ld_req,
   input  logic          ld_we,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_wdata,
   input  logic          ld_lock,
   output logic          ld_gnt,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [DW-1:0] rd_data,
   output logic          if_rvalid,
   output logic          dm_rvalid,
   output logic          ld_rvalid,
   output logic          locked
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

   arb_state_e    r_state, w_state_nxt;
   logic [CW-1:0] r_starve_cnt;
   logic          r_mem_en, r_mem_we, r_rd_pend;
   logic [AW-1:0] r_mem_addr;
   logic [DW-1:0] r_mem_wdata;
   logic [1:0]    r_cmd_tag, r_rsp_tag;

   logic [2:0]    w_gnt;
   logic          w_force_ld, w_locked, w_ld_acc, w_any_acc;
   logic          w_cmd_we;
   logic [AW-1:0] w_cmd_addr;
   logic [DW-1:0] w_cmd_wdata;
   logic [1:0]    w_cmd_tag;

   // Mode inputs are masked in reset so grants then follow the raw requests only.
   assign w_force_ld = rst_n & (r_starve_cnt == LIMIT_C);
   assign w_locked   = rst_n & (r_state == ST_LOCKED);

   mem_arb_prio u_prio (
      .i_reqs     ({ld_req, dm_req, if_req}),
      .i_force_ld (w_force_ld),
      .i_locked   (w_locked),
      .o_gnt      (w_gnt)
   );

   assign if_gnt    = w_gnt[TAG_IF];
   assign dm_gnt    = w_gnt[TAG_DM];
   assign ld_gnt    = w_gnt[TAG_LD];
   assign w_ld_acc  = ld_req & ld_gnt;
   assign w_any_acc = |(w_gnt & {ld_req, dm_req, if_req});

   // Next-state logic for the NORMAL/LOCKED mode FSM
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_NORMAL: begin
            if (w_ld_acc & ld_lock) w_state_nxt = ST_LOCKED;
            else                    w_state_nxt = ST_NORMAL;
         end
         ST_LOCKED: begin
            if (!ld_lock) w_state_nxt = ST_NORMAL;
            else          w_state_nxt = ST_LOCKED;
         end
         default: w_state_nxt = ST_NORMAL;
      endcase
   end

   // Select the winning requester's command fields; fetch never writes and keeps wdata
   always_comb begin
      w_cmd_we    = 1'b0;
      w_cmd_addr  = if_addr;
      w_cmd_wdata = r_mem_wdata;
      w_cmd_tag   = TAG_IF;
      if (w_gnt[TAG_DM]) begin
         w_cmd_we    = dm_we;
         w_cmd_addr  = dm_addr;
         w_cmd_wdata = dm_wdata;
         w_cmd_tag   = TAG_DM;
      end else if (w_gnt[TAG_LD]) begin
         w_cmd_we    = ld_we;
         w_cmd_addr  = ld_addr;
         w_cmd_wdata = ld_wdata;
         w_cmd_tag   = TAG_LD;
      end else begin
         w_cmd_tag   = TAG_IF;
      end
   end

   // Mode FSM and loader starvation counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= ST_NORMAL;
         r_starve_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == ST_LOCKED) || !ld_req || w_ld_acc) begin
            r_starve_cnt <= '0;
         end else if (r_starve_cnt != LIMIT_C) begin
            r_starve_cnt <= r_starve_cnt + CW'(1);
         end else begin
            r_starve_cnt <= r_starve_cnt;
         end
      end
   end

   // Registered memory command and read-response tag pipeline
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_cmd_tag   <= TAG_IF;
         r_rd_pend   <= 1'b0;
         r_rsp_tag   <= TAG_IF;
      end else begin
         r_rd_pend <= r_mem_en & ~r_mem_we;
         r_rsp_tag <= r_cmd_tag;
         if (w_any_acc) begin
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_cmd_we;
            r_mem_addr  <= w_cmd_addr;
            r_mem_wdata <= w_cmd_wdata;
            r_cmd_tag   <= w_cmd_tag;
         end else begin
            r_mem_en    <= 1'b0;
         end
      end
   end

   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign rd_data   = mem_rdata;
   assign if_rvalid = r_rd_pend & (r_rsp_tag == TAG_IF);
   assign dm_rvalid = r_rd_pend & (r_rsp_tag == TAG_DM);
   assign ld_rvalid = r_rd_pend & (r_rsp_tag == TAG_LD);
   assign locked    = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised + directed bench for mem_port_arbiter: a rule-level reference model
// predicts grants and commands; a scoreboard queue checks tagged read returns.
module tb_mem_port_arbiter;

   localparam int AW = 10;
   localparam int DW = 32;
   localparam int SL = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, ld_req = 1'b0, ld_we = 1'b0, ld_lock = 1'b0;
   logic [AW-1:0] if_addr = '0, dm_addr = '0, ld_addr = '0;
   logic [DW-1:0] dm_wdata = '0, ld_wdata = '0;
   logic          if_gnt, dm_gnt, ld_gnt;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata, rd_data;
   logic          if_rvalid, dm_rvalid, ld_rvalid, locked;

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(SL)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
      .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_lock(ld_lock),
      .ld_gnt(ld_gnt),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .rd_data(rd_data),
      .if_rvalid(if_rvalid), .dm_rvalid(dm_rvalid), .ld_rvalid(ld_rvalid), .locked(locked)
   );

   function automatic logic [DW-1:0] init_val(input int a);
      return 32'hA5000000 ^ (a * 32'h00010203);
   endfunction

   // Single-port SRAM with one-cycle read latency; unwritten words return init_val.
   logic [DW-1:0] sram [0:1023];
   bit            wr_flag [0:1023];
   always @(posedge clk) begin
      if (mem_en && !mem_we) mem_rdata <= wr_flag[mem_addr] ? sram[mem_addr] : init_val(int'(mem_addr));
      if (mem_en && mem_we) begin
         sram[mem_addr]    <= mem_wdata;
         wr_flag[mem_addr] <= 1'b1;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [1:0]  tag;
      logic [31:0] data;
      logic [31:0] due;
   } exp_t;
   exp_t q[$];

   int n_vec = 0;
   int n_err = 0;
   bit mon_en = 1'b0;

   // Reference model state
   logic [DW-1:0] ref_mem [0:1023];
   bit            m_locked = 1'b0;
   int            m_starve = 0;
   logic          e_en = 1'b0, e_we = 1'b0;
   logic [AW-1:0] e_addr = '0;
   logic [DW-1:0] e_wdata = '0;

   exp_t          ent;
   logic [2:0]    exp_rv;
   logic [DW-1:0] exp_d;

   always @(negedge clk) begin
      if (mon_en) begin
         n_vec++;
         if ({mem_en, mem_we, mem_addr, locked} !== {e_en, e_we, e_addr, m_locked} ||
             (e_en && e_we && mem_wdata !== e_wdata)) begin
            n_err++;
            $display("FAIL cmd @%0d: got en=%b we=%b addr=%h wd=%h lk=%b, want en=%b we=%b addr=%h wd=%h lk=%b",
                     cyc, mem_en, mem_we, mem_addr, mem_wdata, locked, e_en, e_we, e_addr, e_wdata, m_locked);
         end
         while (q.size() > 0 && int'(q[0].due) < cyc) begin
            ent = q.pop_front();
            n_vec++; n_err++;
            $display("FAIL resp_missed @%0d: tag %0d due %0d never returned", cyc, ent.tag, ent.due);
         end
         exp_rv = 3'b000;
         exp_d  = '0;
         if (q.size() > 0 && int'(q[0].due) == cyc) begin
            ent = q.pop_front();
            exp_rv[ent.tag] = 1'b1;
            exp_d = ent.data;
         end
         n_vec++;
         if ({ld_rvalid, dm_rvalid, if_rvalid} !== exp_rv || (exp_rv != 3'b000 && rd_data !== exp_d)) begin
            n_err++;
            $display("FAIL resp @%0d: got rvalid=%b data=%h, want rvalid=%b data=%h",
                     cyc, {ld_rvalid, dm_rvalid, if_rvalid}, rd_data, exp_rv, exp_d);
         end
      end
   end

   // One clock cycle: drive inputs, check grants against the model, advance the model.
   task automatic step(input logic rst, input logic ir, input logic [AW-1:0] ia,
                       input logic dr, input logic dwe, input logic [AW-1:0] da, input logic [DW-1:0] dwd,
                       input logic lr, input logic lwe, input logic [AW-1:0] la, input logic [DW-1:0] lwd,
                       input logic ll);
      int         w;
      logic [2:0] eg;
      exp_t       ne;
      @(negedge clk);
      #2;
      rst_n = rst; if_req = ir; if_addr = ia;
      dm_req = dr; dm_we = dwe; dm_addr = da; dm_wdata = dwd;
      ld_req = lr; ld_we = lwe; ld_addr = la; ld_wdata = lwd; ld_lock = ll;
      #1;
      if (!rst) begin
         m_locked = 1'b0; m_starve = 0;
         e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
         q.delete();
      end else begin
         if (m_locked)                   w = lr ? 2 : -1;
         else if (lr && m_starve == SL)  w = 2;
         else if (dr)                    w = 1;
         else if (ir)                    w = 0;
         else if (lr)                    w = 2;
         else                            w = -1;
         eg = (w < 0) ? 3'b000 : (3'b001 << w);
         n_vec++;
         if ({ld_gnt, dm_gnt, if_gnt} !== eg) begin
            n_err++;
            $display("FAIL gnt @%0d: got %b, want %b (starve=%0d locked=%0d)",
                     cyc, {ld_gnt, dm_gnt, if_gnt}, eg, m_starve, m_locked);
         end
         if (w >= 0) begin
            e_en = 1'b1;
            case (w)
               0:       begin e_we = 1'b0; e_addr = ia; end
               1:       begin e_we = dwe;  e_addr = da; if (dwe) e_wdata = dwd; end
               default: begin e_we = lwe;  e_addr = la; if (lwe) e_wdata = lwd; end
            endcase
            if (e_we) begin
               ref_mem[e_addr] = e_wdata;
            end else begin
               ne.tag  = 2'(w);
               ne.data = ref_mem[e_addr];
               ne.due  = 32'(cyc + 2);
               q.push_back(ne);
            end
         end else begin
            e_en = 1'b0;
         end
         if (m_locked)              m_starve = 0;
         else if (lr && w != 2)     m_starve = (m_starve < SL) ? m_starve + 1 : SL;
         else                       m_starve = 0;
         if (!m_locked) m_locked = (w == 2) && ll;
         else           m_locked = ll;
      end
   endtask

   task automatic idle();
      step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);

      // Reset with every requester active
      step(1'b0, 1'b1, 10'd1, 1'b1, 1'b0, 10'd2, '0, 1'b1, 1'b0, 10'd3, '0, 1'b1);
      step(1'b0, 1'b1, 10'd1, 1'b1, 1'b0, 10'd2, '0, 1'b1, 1'b0, 10'd3, '0, 1'b1);
      mon_en = 1'b1;
      idle();

      // Fixed priority: all three request, DM load wins
      step(1'b1, 1'b1, 10'd5, 1'b1, 1'b0, 10'd9, '0, 1'b1, 1'b0, 10'd3, '0, 1'b0);
      idle(); idle();

      // Back-to-back fetches
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 10'(i), 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
      idle(); idle();

      // Loader starvation guard
      for (int i = 0; i < 14; i++)
         step(1'b1, 1'b0, '0, 1'b1, 1'b0, 10'(20 + i), '0, 1'b1, 1'b0, 10'd40, '0, 1'b0);
      idle(); idle();

      // Lock mode burst load, fetch and data blocked
      step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 10'h010, 32'hDEADBEEF, 1'b1);
      for (int i = 1; i <= 4; i++)
         step(1'b1, 1'b1, 10'd7, 1'b1, 1'b0, 10'd8, '0, 1'b1, 1'b1, 10'(16 + i), 32'(i * 17), 1'b1);
      step(1'b1, 1'b0, '0, 1'b1, 1'b0, 10'h010, '0, 1'b0, 1'b0, '0, '0, 1'b0);
      step(1'b1, 1'b0, '0, 1'b1, 1'b0, 10'h010, '0, 1'b0, 1'b0, '0, '0, 1'b0);
      idle(); idle();

      // Reset while a data read is in flight
      step(1'b1, 1'b0, '0, 1'b1, 1'b0, 10'd9, '0, 1'b0, 1'b0, '0, '0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
      idle(); idle(); idle();

      // Random traffic with occasional locks and resets
      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(0, 199) != 0),
              1'($urandom), 10'($urandom_range(0, 31)),
              1'($urandom), 1'($urandom), 10'($urandom_range(0, 31)), 32'($urandom),
              1'($urandom), 1'($urandom), 10'($urandom_range(0, 31)), 32'($urandom),
              ($urandom_range(0, 9) == 0));
      end
      for (int i = 0; i < 4; i++) idle();

      n_vec++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d responses still outstanding, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port 1024 x 32 unified instruction/data memory of the pipelined MIPS32 core among three requesters: instruction fetch (IF), data access (MEM stage LW/SW) and a program loader/debug port (LD). Grants one access per cycle under fixed priority, with a starvation guard for the loader and a lock mode for burst program loading. It sits between the pipeline stages and the memory array and returns read data tagged to the requester.

## Interface
- AW, 10, memory word-address width (1024 words)
- DW, 32, data width
- STARVE_LIMIT, 8, consecutive denied loader cycles before the loader is forced to top priority (>= 1)

- clk  in  1  single system clock; all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- if_req / if_addr  in  1 / AW  fetch read request, word address
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- dm_req / dm_we / dm_addr / dm_wdata  in  1 / 1 / AW / DW  data request; we=1 store, we=0 load
- dm_gnt  out  1  data request accepted this cycle
- ld_req / ld_we / ld_addr / ld_wdata / ld_lock  in  1 / 1 / AW / DW / 1  loader request and lock request
- ld_gnt  out  1  loader request accepted this cycle
- mem_en / mem_we / mem_addr / mem_wdata  out  1 / 1 / AW / DW  registered memory command
- mem_rdata  in  DW  memory read data, valid one cycle after mem_en & ~mem_we
- rd_data  out  DW  read data (pass-through of mem_rdata)
- if_rvalid / dm_rvalid / ld_rvalid  out  1  rd_data belongs to this requester this cycle
- locked  out  1  arbiter is in LOCKED state

## Operation
- Accept: requester X accepted at an edge when X_req & X_gnt. At most one gnt high per cycle.
- NORMAL priority: force-loader (starve_cnt == STARVE_LIMIT) > DM > IF > LD.
- starve_cnt: width clog2(STARVE_LIMIT+1); increments, saturating at STARVE_LIMIT, on each edge with ld_req & ~ld_gnt; clears on ld accept or when ld_req low.
- FSM, two states:
  - NORMAL -> LOCKED on an edge where LD is accepted with ld_lock=1.
  - LOCKED: if_gnt=dm_gnt=0, ld_gnt=ld_req; starve_cnt held at 0.
  - LOCKED -> NORMAL on the first edge where ld_lock=0 (grants in that cycle still follow LOCKED rules).
- Command register: on accept, mem_en<=1, mem_we/addr/wdata <= winner's fields (IF: we=0); with no accept, mem_en<=0, other fields hold.
- Response tag: 2-bit tag register plus rd_pend; rd_pend<=mem_en & ~mem_we, tag<=owner of command. X_rvalid = rd_pend & (tag==X). Writes produce no rvalid.
- Addresses are word addresses; no wrap or bounds logic (AW bits index all of memory).

## Timing
- gnt: combinational from req, state, starve_cnt; no req->gnt dependency loop.
- Read: accept at edge E0; mem_en high during E0..E1; SRAM samples at E1; X_rvalid and rd_data valid during E1..E2; requester samples at E2. Latency 2 edges; fully pipelined, one access per cycle.
- Write: accept at E0; memory written at E1.
- Back-to-back reads from different requesters return in acceptance order, one per cycle.
- Reset (rst_n low at an edge): state NORMAL, starve_cnt 0, mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0, rd_pend 0, all rvalid 0, locked 0. gnts depend only on reqs during reset and are ignored. Reset mid-read drops the pending response; no rvalid after reset.
- Simultaneous req of all three with starve_cnt < STARVE_LIMIT: DM wins. In LOCKED, ld_req low: no grant, mem_en 0.

## Structure
- Shared package mem_arb_pkg: requester tag constants (TAG_IF=0, TAG_DM=1, TAG_LD=2), state encoding (NORMAL=0, LOCKED=1), default AW/DW.
- One natural sub-module: mem_arb_prio, a combinational priority picker (inputs: reqs, force_ld, locked; outputs: one-hot gnt). Counter, FSM and command/response registers stay in the top.

## Test plan
- Reset: hold rst_n=0 two cycles with all reqs high -> after release mem_en=0, all rvalid 0, locked 0, starve_cnt 0.
- Priority: IF addr 5, DM load addr 9, LD addr 3 same cycle -> dm_gnt only; mem_addr=9 next cycle; dm_rvalid and rd_data=Mem[9] two edges after accept.
- Pipelining: IF reads 0,1,2 on consecutive cycles -> if_rvalid high 3 consecutive cycles, rd_data Mem[0],Mem[1],Mem[2].
- Starvation: STARVE_LIMIT=8, DM and LD req continuously -> LD denied 8 edges, ld_gnt on 9th cycle, counter back to 0, DM resumes.
- Lock: LD store with ld_lock=1 addr 0x10 data 0xDEADBEEF, then 4 locked stores while IF/DM req -> if_gnt=dm_gnt=0 throughout, locked=1; drop ld_lock -> NORMAL next edge, DM granted; readback 0x10 = 0xDEADBEEF.
- Reset mid-read: DM load accepted, rst_n low next edge -> no dm_rvalid afterwards, mem_en 0.
